mem_bus_ctrl: RTL and testbench

//  Bus adapter directly downstream of the memory pipeline stage. It converts that stage's

---
 rtl/mem_bus_ctrl_if.sv | 37 +++
 rtl/mem_bus_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
// Signal bundle between the memory pipeline stage, mem_bus_ctrl and the external memory bus.
// The slave modport is the controller's view; master is the surrounding pipeline/bus view.
interface mem_bus_ctrl_if #(
  parameter int ADDR_W = 24
);
  // Handshake: the pipeline holds mem_* stable while stall_o=1. The controller holds every
  // bus_* output stable while bus_cyc_o=1. The access ends on the posedge where bus_ack_i=1
  // with bus_cyc_o=1, and bus_rdata_i is valid in that same cycle.
  logic              mem_re_i;
  logic              mem_we_i;
  logic              mem_byte_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [15:0]       mem_wdata_i;
  logic [15:0]       mem_rdata_o;
  logic              stall_o;
  logic              bus_cyc_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [1:0]        bus_be_o;
  logic [15:0]       bus_wdata_o;
  logic              bus_ack_i;
  logic [15:0]       bus_rdata_i;
  logic              bus_err_o;
  logic [1:0]        dbg_state_o;

  modport slave (
    input  mem_re_i, mem_we_i, mem_byte_i, mem_addr_i, mem_wdata_i, bus_ack_i, bus_rdata_i,
    output mem_rdata_o, stall_o, bus_cyc_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
           bus_err_o, dbg_state_o
  );

  modport master (
    output mem_re_i, mem_we_i, mem_byte_i, mem_addr_i, mem_wdata_i, bus_ack_i, bus_rdata_i,
    input  mem_rdata_o, stall_o, bus_cyc_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
           bus_err_o, dbg_state_o
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Converts single-cycle mem_re/mem_we strobes into a req/ack cycle on a wait-state memory bus.
// Optional bus timeout with error pulse is enabled by defining MEM_TIMEOUT_EN.
module mem_bus_ctrl #(
  parameter int ADDR_W         = 24,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst,
  mem_bus_ctrl_if.slave  io
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        be_q, be_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              req;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // A write wins over a simultaneous read; the read is simply dropped.
  assign req = io.mem_re_i | io.mem_we_i;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_BUS;
          cyc_d   = 1'b1;
          we_d    = io.mem_we_i;
          rd_d    = ~io.mem_we_i;
          addr_d  = {io.mem_addr_i[ADDR_W-1:1], 1'b0};
          // Big-endian lanes: the even byte address lives in bits [15:8].
          if (io.mem_we_i && io.mem_byte_i) begin
            if (io.mem_addr_i[0]) begin
              be_d    = 2'b01;
              wdata_d = {8'h00, io.mem_wdata_i[7:0]};
            end else begin
              be_d    = 2'b10;
              wdata_d = {io.mem_wdata_i[7:0], 8'h00};
            end
          end else begin
            be_d    = 2'b11;
            wdata_d = io.mem_wdata_i;
          end
`ifdef MEM_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      ST_BUS: begin
        if (io.bus_ack_i) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          if (rd_q) rdata_d = io.bus_rdata_i;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          if (rd_q) rdata_d = 16'hFFFF;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 2'b00;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign io.stall_o     = req & (state_q != ST_DONE);
  assign io.bus_cyc_o   = cyc_q;
  assign io.bus_we_o    = we_q;
  assign io.bus_addr_o  = addr_q;
  assign io.bus_be_o    = be_q;
  assign io.bus_wdata_o = wdata_q;
  assign io.mem_rdata_o = rdata_q;
  assign io.dbg_state_o = state_q;
`ifdef MEM_TIMEOUT_EN
  assign io.bus_err_o   = err_q;
`else
  assign io.bus_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed scenarios plus randomized accesses
// against a transaction-level reference model.
module tb_mem_bus_ctrl;
`ifdef MEM_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  logic [15:0] rdata_model = 16'h0000;
  logic [15:0] exp_q[$];

  mem_bus_ctrl_if #(.ADDR_W(24)) bif ();

  mem_bus_ctrl #(.ADDR_W(24), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bif.mem_re_i    = 1'b0;
    bif.mem_we_i    = 1'b0;
    bif.mem_byte_i  = 1'b0;
    bif.mem_addr_i  = '0;
    bif.mem_wdata_i = '0;
    bif.bus_ack_i   = 1'b0;
  endtask

  // Call at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle after DONE.
  task automatic do_access(input bit re, input bit we, input bit byt, input logic [23:0] addr,
                           input logic [15:0] d, input int waits, input logic [15:0] rd);
    int          stall_n = 0;
    int          cyc_n   = 0;
    bit          done    = 1'b0;
    bit          to_exp;
    bit          bytew;
    logic [1:0]  exp_be;
    logic [15:0] exp_wd;
    logic [15:0] got;
    to_exp = TO_EN && (waits >= TO);
    bytew  = we && byt;
    exp_be = !bytew ? 2'b11 : (addr[0] ? 2'b01 : 2'b10);
    exp_wd = !bytew ? d : (addr[0] ? {8'h00, d[7:0]} : {d[7:0], 8'h00});
    if (!we) rdata_model = to_exp ? 16'hFFFF : rd;
    exp_q.push_back(rdata_model);

    bif.mem_re_i    = re;
    bif.mem_we_i    = we;
    bif.mem_byte_i  = byt;
    bif.mem_addr_i  = addr;
    bif.mem_wdata_i = d;
    bif.bus_rdata_i = rd;
    for (int c = 0; c < 400 && !done; c++) begin
      #1;
      if (c == 0) chk("launch_cyc_low", {31'd0, bif.bus_cyc_o}, 32'd0);
      if (bif.bus_cyc_o) begin
        cyc_n++;
        if (cyc_n == 1) begin
          chk("bus_addr", {8'd0, bif.bus_addr_o}, {8'd0, addr[23:1], 1'b0});
          chk("bus_be", {30'd0, bif.bus_be_o}, {30'd0, exp_be});
          chk("bus_we", {31'd0, bif.bus_we_o}, {31'd0, we});
          if (we) chk("bus_wdata", {16'd0, bif.bus_wdata_o}, {16'd0, exp_wd});
        end
        bif.bus_ack_i = (cyc_n == waits + 1);
      end else begin
        bif.bus_ack_i = 1'b0;
      end
      if (!bif.stall_o) begin
        done = 1'b1;
        got  = exp_q.pop_front();
        chk("mem_rdata", {16'd0, bif.mem_rdata_o}, {16'd0, got});
        chk("bus_err", {31'd0, bif.bus_err_o}, {31'd0, to_exp});
      end else begin
        stall_n++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("access_bound", 32'd0, 32'd1);
    chk("stall_cycles", stall_n, to_exp ? TO + 1 : waits + 2);
    chk("cyc_cycles", cyc_n, to_exp ? TO : waits + 1);
    drive_idle();
  endtask

  initial begin
    bit          re, we, byt;
    int          sel;
    drive_idle();
    bif.bus_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cyc", {31'd0, bif.bus_cyc_o}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_we", {31'd0, bif.bus_we_o}, 32'd0);
    chk("rst_be", {30'd0, bif.bus_be_o}, 32'd0);
    chk("rst_addr", {8'd0, bif.bus_addr_o}, 32'd0);
    chk("rst_wdata", {16'd0, bif.bus_wdata_o}, 32'd0);
    chk("rst_rdata", {16'd0, bif.mem_rdata_o}, 32'd0);
    chk("rst_err", {31'd0, bif.bus_err_o}, 32'd0);
    chk("rst_stall", {31'd0, bif.stall_o}, 32'd0);
    @(posedge clk);
    #1;

    // Directed scenarios
    do_access(1'b1, 1'b0, 1'b0, 24'h000102, 16'h0000, 0, 16'hBEEF);
    do_access(1'b0, 1'b1, 1'b1, 24'h000011, 16'h00A5, 3, 16'h5555);
    do_access(1'b0, 1'b1, 1'b1, 24'h000040, 16'h3C7E, 1, 16'h5555);
    do_access(1'b1, 1'b1, 1'b0, 24'h000020, 16'h1234, 0, 16'hDEAD);
    do_access(1'b1, 1'b0, 1'b0, 24'h000200, 16'h0000, 1, 16'hA1A1);
    do_access(1'b1, 1'b0, 1'b0, 24'h000203, 16'h0000, 2, 16'hB2B2);
    // Long wait: timeout when enabled, plain wait otherwise; then ack exactly at expiry
    do_access(1'b1, 1'b0, 1'b0, 24'h000300, 16'h0000, 10, 16'h7777);
    do_access(1'b1, 1'b0, 1'b0, 24'h000302, 16'h0000, TO - 1, 16'h6543);

    // Async reset in the middle of a bus cycle
    bif.mem_re_i   = 1'b1;
    bif.mem_addr_i = 24'h000500;
    bif.bus_rdata_i = 16'h9999;
    @(posedge clk);
    #1;
    chk("midbus_cyc_high", {31'd0, bif.bus_cyc_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midbus_rst_cyc", {31'd0, bif.bus_cyc_o}, 32'd0);
    chk("midbus_rst_stall", {31'd0, bif.stall_o}, 32'd1);
    chk("midbus_rst_rdata", {16'd0, bif.mem_rdata_o}, 32'd0);
    rdata_model = 16'h0000;
    bif.mem_re_i = 1'b0;
    #1;
    chk("midbus_rst_stall_drop", {31'd0, bif.stall_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_cyc", {31'd0, bif.bus_cyc_o}, 32'd0);

    // Randomized accesses
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(1, 3);
      re  = sel[0];
      we  = sel[1];
      byt = $urandom_range(0, 1);
      do_access(re, we, byt, 24'($urandom), 16'($urandom), $urandom_range(0, 5),
                16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
